// File: rtl/zeckendorf_pkg.sv
// Shared definitions for the Zeckendorf encoder: Fibonacci weights, range limit
// and FSM state encoding.
package zeckendorf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Weight of codeword bit i, i.e. Fib(i+2): 1, 2, 3, 5, 8, 13, ...
  function automatic int unsigned fib_weight(input int unsigned i);
    int unsigned a;
    int unsigned b;
    int unsigned t;
    a = 1;
    b = 2;
    for (int unsigned k = 0; k < i; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Largest value representable by an n-bit codeword: Fib(n+2)-1.
  function automatic int unsigned max_val(input int unsigned n);
    return fib_weight(n) - 1;
  endfunction

endpackage

// File: rtl/zeckendorf_if.sv
// Producer/consumer handshake bundle for the Zeckendorf encoder.
interface zeckendorf_if #(
  parameter int N_BITS = 8,
  parameter int IN_W   = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [N_BITS-1:0] out_code;
  logic              out_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code, out_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code, out_err
  );
endinterface

// File: rtl/zeckendorf_encoder.sv
// Bit-serial greedy Zeckendorf encoder: one codeword bit per clock, MSB first,
// valid/ready on both sides.
module zeckendorf_encoder
  import zeckendorf_pkg::*;
#(
  parameter int N_BITS = 8,
  parameter int IN_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  zeckendorf_if.slave bus
);

  localparam int unsigned MAX_VAL = max_val(N_BITS);
  localparam int W_TOP_W = $clog2(fib_weight(N_BITS - 1) + 1);
  localparam int SUB_W   = (IN_W > W_TOP_W) ? IN_W : W_TOP_W;
  localparam int IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [IN_W-1:0] MAX_VAL_W = IN_W'(MAX_VAL);

  logic [SUB_W-1:0] weight [N_BITS];

  generate
    for (genvar gi = 0; gi < N_BITS; gi++) begin : g_weight
      assign weight[gi] = SUB_W'(fib_weight(gi));
    end
  endgenerate

  // Reset asserts immediately but is released on a clock edge.
  logic rst_meta_reg;
  logic rst_sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_meta_reg <= 1'b1;
      rst_sync_reg <= 1'b1;
    end else begin
      rst_meta_reg <= 1'b0;
      rst_sync_reg <= rst_meta_reg;
    end
  end

  state_t            state_reg, state_next;
  logic [SUB_W-1:0]  rem_reg,   rem_next;
  logic [IDX_W-1:0]  idx_reg,   idx_next;
  logic [N_BITS-1:0] code_reg,  code_next;
  logic              skip_reg,  skip_next;
  logic              err_reg,   err_next;

  always_ff @(posedge clk or posedge rst_sync_reg) begin
    if (rst_sync_reg) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      idx_reg   <= '0;
      code_reg  <= '0;
      skip_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      idx_reg   <= idx_next;
      code_reg  <= code_next;
      skip_reg  <= skip_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    idx_next   = idx_reg;
    code_next  = code_reg;
    skip_next  = skip_reg;
    err_next   = err_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          code_next  = '0;
          skip_next  = 1'b0;
          idx_next   = IDX_W'(N_BITS - 1);
          state_next = CONVERT;
          if (bus.in_data > MAX_VAL_W) begin
            // Out-of-range values spend a single cycle in CONVERT so the
            // error result appears one cycle after acceptance.
            err_next = 1'b1;
            rem_next = '0;
          end else begin
            err_next = 1'b0;
            rem_next = SUB_W'(bus.in_data);
          end
        end
      end

      CONVERT: begin
        if (err_reg) begin
          state_next = DONE;
        end else begin
          if (skip_reg) begin
            skip_next = 1'b0;
          end else if (rem_reg >= weight[idx_reg]) begin
            code_next[idx_reg] = 1'b1;
            rem_next           = rem_reg - weight[idx_reg];
            skip_next          = 1'b1;
          end
          if (idx_reg == '0) begin
            state_next = DONE;
          end else begin
            idx_next = idx_reg - IDX_W'(1);
          end
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
          err_next   = 1'b0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_code  = code_reg;
  assign bus.out_err   = err_reg;

endmodule

// File: tb/tb_zeckendorf_encoder.sv
// Self-checking bench for zeckendorf_encoder: directed vector table, reset and
// backpressure sequences, and a full input sweep against a brute-force model.
module tb_zeckendorf_encoder;

  localparam int N_BITS  = 8;
  localparam int IN_W    = 6;
  localparam int MAX_IN  = 54;
  localparam int TIMEOUT = 50;

  logic clk;
  logic rst;

  zeckendorf_if #(.N_BITS(N_BITS), .IN_W(IN_W)) bus ();

  zeckendorf_encoder #(.N_BITS(N_BITS), .IN_W(IN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  // Brute-force reference: every fibbinary codeword, indexed by its value.
  int unsigned fib_w [N_BITS];
  logic [N_BITS-1:0] ref_code [int];

  typedef struct {
    logic [IN_W-1:0]   din;
    logic [N_BITS-1:0] code;
    logic              err;
    int                lat;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full request/response; hold = cycles out_ready stays low once valid,
  // early = out_ready already high throughout conversion.
  task automatic run_txn(input logic [IN_W-1:0] val, input int hold, input bit early,
                         output logic [N_BITS-1:0] code, output logic err, output int lat);
    check("in_ready_before", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = val;
    bus.out_ready = early;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    lat = 0;
    while (!bus.out_valid && lat < TIMEOUT) begin
      check("in_ready_busy", {31'b0, bus.in_ready}, 32'd0);
      tick();
      lat++;
    end
    if (!bus.out_valid) begin
      check("timeout", 32'd0, 32'd1);
      code = '0;
      err  = 1'b0;
      return;
    end
    code = bus.out_code;
    err  = bus.out_err;
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        tick();
        check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
        check("hold_code", {24'b0, bus.out_code}, {24'b0, code});
        check("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
    end
    tick();
    bus.out_ready = 1'b0;
    check("valid_after_xfer", {31'b0, bus.out_valid}, 32'd0);
    check("err_after_xfer", {31'b0, bus.out_err}, 32'd0);
  endtask

  logic [N_BITS-1:0] got_code;
  logic              got_err;
  int                got_lat;
  int unsigned       sum;
  int unsigned       ones;

  initial begin
    n_vec = 0;
    n_bad = 0;

    fib_w[0] = 1;
    fib_w[1] = 2;
    for (int i = 2; i < N_BITS; i++) fib_w[i] = fib_w[i-1] + fib_w[i-2];
    for (int c = 0; c < (1 << N_BITS); c++) begin
      if ((c & (c >> 1)) == 0) begin
        sum = 0;
        for (int b = 0; b < N_BITS; b++) if (c[b]) sum += fib_w[b];
        ref_code[int'(sum)] = N_BITS'(c);
      end
    end

    vecs[0] = '{din: 6'd0,  code: 8'b00000000, err: 1'b0, lat: 8};
    vecs[1] = '{din: 6'd12, code: 8'b00010101, err: 1'b0, lat: 8};
    vecs[2] = '{din: 6'd20, code: 8'b00101010, err: 1'b0, lat: 8};
    vecs[3] = '{din: 6'd54, code: 8'b10101010, err: 1'b0, lat: 8};
    vecs[4] = '{din: 6'd55, code: 8'b00000000, err: 1'b1, lat: 1};
    vecs[5] = '{din: 6'd63, code: 8'b00000000, err: 1'b1, lat: 1};
    vecs[6] = '{din: 6'd1,  code: 8'b00000001, err: 1'b0, lat: 8};
    vecs[7] = '{din: 6'd33, code: 8'b01010101, err: 1'b0, lat: 8};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_code", {24'b0, bus.out_code}, 32'd0);
    check("rst_out_err", {31'b0, bus.out_err}, 32'd0);
    rst = 1'b0;
    repeat (4) tick();

    for (int v = 0; v < 8; v++) begin
      run_txn(vecs[v].din, 0, 1'b1, got_code, got_err, got_lat);
      $display("vec %0d: in=%0d code=%b err=%0d lat=%0d", v, vecs[v].din, got_code, got_err, got_lat);
      check("vec_code", {24'b0, got_code}, {24'b0, vecs[v].code});
      check("vec_err", {31'b0, got_err}, {31'b0, vecs[v].err});
      check("vec_lat", got_lat, vecs[v].lat);
    end

    // Backpressure: result must stay put for five stalled cycles.
    run_txn(6'd4, 5, 1'b0, got_code, got_err, got_lat);
    $display("backpressure: in=4 code=%b err=%0d lat=%0d", got_code, got_err, got_lat);
    check("bp_code", {24'b0, got_code}, 32'h05);
    check("bp_lat", got_lat, 8);

    // Reset mid-conversion discards the partial result immediately.
    bus.in_valid = 1'b1;
    bus.in_data  = 6'd33;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    $display("mid-convert reset: code=%b valid=%0d ready=%0d", bus.out_code, bus.out_valid, bus.in_ready);
    check("midrst_out_code", {24'b0, bus.out_code}, 32'd0);
    check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("midrst_out_err", {31'b0, bus.out_err}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    run_txn(6'd33, 1, 1'b0, got_code, got_err, got_lat);
    $display("after reset: in=33 code=%b err=%0d", got_code, got_err);
    check("post_rst_code", {24'b0, got_code}, 32'h55);

    // Full sweep with randomized consumer stalls.
    for (int x = 0; x < (1 << IN_W); x++) begin
      run_txn(IN_W'(x), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              got_code, got_err, got_lat);
      $display("sweep: in=%0d code=%b err=%0d lat=%0d", x, got_code, got_err, got_lat);
      check("sweep_err", {31'b0, got_err}, {31'b0, (x > MAX_IN)});
      if (x <= MAX_IN) begin
        check("sweep_code", {24'b0, got_code}, {24'b0, ref_code[x]});
        ones = 32'(got_code & (got_code >> 1));
        check("sweep_adjacent", ones, 32'd0);
        check("sweep_lat", got_lat, N_BITS);
      end else begin
        check("sweep_err_code", {24'b0, got_code}, 32'd0);
        check("sweep_err_lat", got_lat, 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
